// File: rtl/csr_pkg.sv
// Shared CSR sizing constants and encoder state type, common to the encoder and
// the SpMV kernel so both ends of the CSR interface agree on array sizes.
package csr_pkg;

   localparam int CSR_N      = 494;
   localparam int CSR_NNZ    = 1666;
   localparam int CSR_DATA_W = 64;
   localparam int CSR_IDX_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HEAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } csr_enc_state_t;

endpackage

// File: rtl/csr_out_slot.sv
// One-entry registered valid/ready output slot. A load in the same cycle as a
// consume replaces the data without dropping valid, so there is no bubble.
module csr_out_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] ld_data,
   output logic [W-1:0] data,
   output logic         valid,
   input  logic         ready,
   output logic         free
);

   logic [W-1:0] data_r;
   logic         valid_r;

   // Holding register: reload wins over consume, otherwise hold until ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r  <= {W{1'b0}};
         valid_r <= 1'b0;
      end else if (load) begin
         data_r  <= ld_data;
         valid_r <= 1'b1;
      end else if (ready) begin
         valid_r <= 1'b0;
      end
   end

   assign data  = data_r;
   assign valid = valid_r;
   assign free  = ~valid_r | ready;

endmodule

// File: rtl/csr_encoder.sv
// Streaming dense-to-CSR encoder: row-major dense elements in, nonzero {val,col}
// beats and cumulative row delimiters out on two independent valid/ready slots.
module csr_encoder
   import csr_pkg::*;
#(
   parameter int N_ROWS  = CSR_N,
   parameter int N_COLS  = CSR_N,
   parameter int MAX_NNZ = CSR_NNZ,
   parameter int DATA_W  = CSR_DATA_W,
   parameter int IDX_W   = CSR_IDX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] nz_val,
   output logic [IDX_W-1:0]  nz_col,
   output logic              nz_valid,
   input  logic              nz_ready,
   output logic [IDX_W-1:0]  rp_data,
   output logic              rp_valid,
   input  logic              rp_ready,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam int R_W  = $clog2(N_ROWS + 1);
   localparam int C_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam int NZ_W = DATA_W + IDX_W;

   csr_enc_state_t    state_r, state_s;
   logic [R_W-1:0]    row_r;
   logic [C_W-1:0]    col_r;
   logic [IDX_W-1:0]  nnz_r, nnz_next_s, rp_ld_s;
   logic              overflow_r, busy_r, done_r;
   logic              nz_free_s, rp_free_s, in_ready_s, accept_s;
   logic              nonzero_s, room_s, last_col_s, last_row_s;
   logic              nz_load_s, rp_load_s, ovf_set_s, clear_s, finish_s;
   logic [NZ_W-1:0]   nz_slot_s;

   assign nonzero_s  = |in_data;
   assign room_s     = nnz_r < IDX_W'(MAX_NNZ);
   assign last_col_s = col_r == C_W'(N_COLS - 1);
   assign last_row_s = row_r == R_W'(N_ROWS - 1);

   // Next-state, handshake and slot-load decode.
   always_comb begin
      state_s    = state_r;
      in_ready_s = 1'b0;
      accept_s   = 1'b0;
      nz_load_s  = 1'b0;
      rp_load_s  = 1'b0;
      rp_ld_s    = {IDX_W{1'b0}};
      nnz_next_s = nnz_r;
      ovf_set_s  = 1'b0;
      clear_s    = 1'b0;
      finish_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               clear_s = 1'b1;
               state_s = ST_HEAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HEAD: begin
            if (rp_free_s) begin
               rp_load_s = 1'b1;
               state_s   = ST_RUN;
            end else begin
               state_s = ST_HEAD;
            end
         end
         ST_RUN: begin
            in_ready_s = nz_free_s & rp_free_s;
            accept_s   = in_ready_s & in_valid;
            if (accept_s) begin
               if (nonzero_s && room_s) begin
                  nz_load_s  = 1'b1;
                  nnz_next_s = nnz_r + IDX_W'(1'b1);
               end else if (nonzero_s) begin
                  ovf_set_s = 1'b1;
               end else begin
                  nnz_next_s = nnz_r;
               end
               // Row wrap publishes the count including the current element.
               if (last_col_s) begin
                  rp_load_s = 1'b1;
                  rp_ld_s   = nnz_next_s;
                  state_s   = last_row_s ? ST_DRAIN : ST_RUN;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (nz_free_s && rp_free_s) begin
               finish_s = 1'b1;
               state_s  = ST_IDLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         row_r      <= {R_W{1'b0}};
         col_r      <= {C_W{1'b0}};
         nnz_r      <= {IDX_W{1'b0}};
         overflow_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r <= state_s;
         done_r  <= finish_s;
         if (clear_s) begin
            row_r      <= {R_W{1'b0}};
            col_r      <= {C_W{1'b0}};
            nnz_r      <= {IDX_W{1'b0}};
            overflow_r <= 1'b0;
            busy_r     <= 1'b1;
         end else begin
            if (accept_s) begin
               nnz_r <= nnz_next_s;
               col_r <= last_col_s ? {C_W{1'b0}} : col_r + C_W'(1'b1);
               row_r <= last_col_s ? row_r + R_W'(1'b1) : row_r;
            end
            if (ovf_set_s) begin
               overflow_r <= 1'b1;
            end
            if (finish_s) begin
               busy_r <= 1'b0;
            end
         end
      end
   end

   csr_out_slot #(.W(NZ_W)) u_nz_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (nz_load_s),
      .ld_data ({in_data, IDX_W'(col_r)}),
      .data    (nz_slot_s),
      .valid   (nz_valid),
      .ready   (nz_ready),
      .free    (nz_free_s)
   );

   csr_out_slot #(.W(IDX_W)) u_rp_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (rp_load_s),
      .ld_data (rp_ld_s),
      .data    (rp_data),
      .valid   (rp_valid),
      .ready   (rp_ready),
      .free    (rp_free_s)
   );

   assign nz_val   = nz_slot_s[NZ_W-1:IDX_W];
   assign nz_col   = nz_slot_s[IDX_W-1:0];
   assign in_ready = in_ready_s;
   assign busy     = busy_r;
   assign done     = done_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_csr_encoder.sv
// Directed bench for csr_encoder: a 3x3 instance and a 2x2 instance with MAX_NNZ=2,
// hand-computed CSR streams checked with immediate assertions.
module tb_csr_encoder;

   localparam int DW = 16;
   localparam int IW = 32;
   localparam int EW = DW + IW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vec  = 0;
   int errs = 0;

   logic          a_start, a_in_valid, a_in_ready, a_nz_valid, a_nz_ready;
   logic          a_rp_valid, a_rp_ready, a_busy, a_done, a_overflow;
   logic [DW-1:0] a_in_data, a_nz_val;
   logic [IW-1:0] a_nz_col, a_rp_data;
   logic          b_start, b_in_valid, b_in_ready, b_nz_valid, b_nz_ready;
   logic          b_rp_valid, b_rp_ready, b_busy, b_done, b_overflow;
   logic [DW-1:0] b_in_data, b_nz_val;
   logic [IW-1:0] b_nz_col, b_rp_data;

   csr_encoder #(.N_ROWS(3), .N_COLS(3), .MAX_NNZ(16), .DATA_W(DW), .IDX_W(IW)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .nz_val(a_nz_val), .nz_col(a_nz_col), .nz_valid(a_nz_valid),
      .nz_ready(a_nz_ready), .rp_data(a_rp_data), .rp_valid(a_rp_valid), .rp_ready(a_rp_ready),
      .busy(a_busy), .done(a_done), .overflow(a_overflow)
   );

   csr_encoder #(.N_ROWS(2), .N_COLS(2), .MAX_NNZ(2), .DATA_W(DW), .IDX_W(IW)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .nz_val(b_nz_val), .nz_col(b_nz_col), .nz_valid(b_nz_valid),
      .nz_ready(b_nz_ready), .rp_data(b_rp_data), .rp_valid(b_rp_valid), .rp_ready(b_rp_ready),
      .busy(b_busy), .done(b_done), .overflow(b_overflow)
   );

   logic [EW-1:0] a_nzq[$], b_nzq[$], e_nz[$];
   logic [IW-1:0] a_rpq[$], b_rpq[$], e_rp[$];
   int a_last = 0, b_last = 0, a_done_cnt = 0;

   // Handshake monitor: inputs only change just after posedge, so negedge sees the
   // values that the next posedge will act on.
   always @(negedge clk) begin
      if (a_nz_valid && a_nz_ready) begin a_nzq.push_back({a_nz_val, a_nz_col}); a_last <= cyc; end
      if (a_rp_valid && a_rp_ready) begin a_rpq.push_back(a_rp_data); a_last <= cyc; end
      if (b_nz_valid && b_nz_ready) begin b_nzq.push_back({b_nz_val, b_nz_col}); b_last <= cyc; end
      if (b_rp_valid && b_rp_ready) begin b_rpq.push_back(b_rp_data); b_last <= cyc; end
      if (a_done) a_done_cnt <= a_done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_nz(input string tag, input logic [EW-1:0] got[$], input int base);
      logic [EW-1:0] g;
      chk({tag, "_nz_count"}, 64'(got.size() - base), 64'(e_nz.size()));
      for (int i = 0; i < e_nz.size(); i++) begin
         g = (base + i < got.size()) ? got[base + i] : {EW{1'b1}};
         chk({tag, "_nz_beat"}, 64'(g), 64'(e_nz[i]));
      end
   endtask

   task automatic chk_rp(input string tag, input logic [IW-1:0] got[$], input int base);
      logic [IW-1:0] g;
      chk({tag, "_rp_count"}, 64'(got.size() - base), 64'(e_rp.size()));
      for (int i = 0; i < e_rp.size(); i++) begin
         g = (base + i < got.size()) ? got[base + i] : {IW{1'b1}};
         chk({tag, "_rp_delim"}, 64'(g), 64'(e_rp[i]));
      end
   endtask

   task automatic pulse_start(input bit sel);
      if (sel) b_start = 1'b1; else a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      b_start = 1'b0;
   endtask

   task automatic feed(input bit sel, input logic [DW-1:0] v);
      bit acc;
      acc = 1'b0;
      if (sel) begin b_in_data = v; b_in_valid = 1'b1; end
      else begin a_in_data = v; a_in_valid = 1'b1; end
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         acc = sel ? b_in_ready : a_in_ready;
         if (!acc) begin @(posedge clk); #1; end
      end
      if (!acc) begin
         vec++; errs++;
         $error("FAIL in_accept: observed no in_ready, expected accept within 50 cycles");
      end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
   endtask

   task automatic wait_done(input bit sel, input string tag);
      bit seen;
      int last;
      seen = 1'b0;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(negedge clk);
         seen = sel ? b_done : a_done;
      end
      last = sel ? b_last : a_last;
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      chk({tag, "_done_lat"}, 64'(cyc), 64'(last + 1));
      chk({tag, "_busy_fall"}, 64'(sel ? b_busy : a_busy), 64'd0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(sel ? b_done : a_done), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_in_ready"}, 64'(a_in_ready), 64'd0);
      chk({tag, "_nz_val"},   64'(a_nz_val),   64'd0);
      chk({tag, "_nz_col"},   64'(a_nz_col),   64'd0);
      chk({tag, "_nz_valid"}, 64'(a_nz_valid), 64'd0);
      chk({tag, "_rp_data"},  64'(a_rp_data),  64'd0);
      chk({tag, "_rp_valid"}, 64'(a_rp_valid), 64'd0);
      chk({tag, "_busy"},     64'(a_busy),     64'd0);
      chk({tag, "_done"},     64'(a_done),     64'd0);
      chk({tag, "_overflow"}, 64'(a_overflow), 64'd0);
   endtask

   logic [DW-1:0] m1[9];
   logic [DW-1:0] mid[9];
   int nb, rb, dsnap;

   initial begin
      m1  = '{16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3};
      mid = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
      a_start = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_nz_ready = 1'b1; a_rp_ready = 1'b1;
      b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_nz_ready = 1'b1; b_rp_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_a("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // 3x3 [[5,0,0],[0,0,0],[1,2,3]] with start-to-HEAD timing
      e_nz = '{{16'd5, 32'd0}, {16'd1, 32'd0}, {16'd2, 32'd1}, {16'd3, 32'd2}};
      e_rp = '{32'd0, 32'd1, 32'd1, 32'd4};
      nb = a_nzq.size(); rb = a_rpq.size();
      pulse_start(1'b0);
      chk("t1_busy_t1", 64'(a_busy), 64'd1);
      chk("t1_rp_valid_t1", 64'(a_rp_valid), 64'd0);
      chk("t1_in_ready_t1", 64'(a_in_ready), 64'd0);
      @(posedge clk); #1;
      chk("t1_rp_valid_t2", 64'(a_rp_valid), 64'd1);
      chk("t1_in_ready_t2", 64'(a_in_ready), 64'd1);
      for (int i = 0; i < 9; i++) feed(1'b0, m1[i]);
      wait_done(1'b0, "t1");
      chk_nz("t1", a_nzq, nb);
      chk_rp("t1", a_rpq, rb);
      chk("t1_overflow", 64'(a_overflow), 64'd0);

      // 2x2 all-ones with MAX_NNZ=2: saturation and sticky overflow
      e_nz = '{{16'd1, 32'd0}, {16'd1, 32'd1}};
      e_rp = '{32'd0, 32'd2, 32'd2};
      nb = b_nzq.size(); rb = b_rpq.size();
      pulse_start(1'b1);
      feed(1'b1, 16'd1);
      feed(1'b1, 16'd1);
      chk("t4_ovf_after2", 64'(b_overflow), 64'd0);
      feed(1'b1, 16'd1);
      chk("t4_ovf_after3", 64'(b_overflow), 64'd1);
      feed(1'b1, 16'd1);
      wait_done(1'b1, "t4");
      chk("t4_ovf_sticky", 64'(b_overflow), 64'd1);
      chk_nz("t4", b_nzq, nb);
      chk_rp("t4", b_rpq, rb);

      // 2x2 all-zero; the new start also clears overflow
      e_nz = {};
      e_rp = '{32'd0, 32'd0, 32'd0};
      nb = b_nzq.size(); rb = b_rpq.size();
      pulse_start(1'b1);
      chk("t2_ovf_cleared", 64'(b_overflow), 64'd0);
      for (int i = 0; i < 4; i++) feed(1'b1, 16'd0);
      wait_done(1'b1, "t2");
      chk_nz("t2", b_nzq, nb);
      chk_rp("t2", b_rpq, rb);
      chk("t2_overflow", 64'(b_overflow), 64'd0);

      // 3x3 identity with nz consumer stalled for 5 cycles in row 1
      e_nz = '{{16'd1, 32'd0}, {16'd1, 32'd1}, {16'd1, 32'd2}};
      e_rp = '{32'd0, 32'd1, 32'd2, 32'd3};
      nb = a_nzq.size(); rb = a_rpq.size();
      pulse_start(1'b0);
      for (int i = 0; i < 5; i++) feed(1'b0, mid[i]);
      a_nz_ready = 1'b0;
      a_in_data = mid[5];
      a_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_stall_in_ready", 64'(a_in_ready), 64'd0);
         chk("t3_stall_nz_val", 64'(a_nz_val), 64'd1);
         chk("t3_stall_nz_col", 64'(a_nz_col), 64'd1);
         @(posedge clk); #1;
      end
      a_nz_ready = 1'b1;
      for (int i = 5; i < 9; i++) feed(1'b0, mid[i]);
      wait_done(1'b0, "t3");
      chk_nz("t3", a_nzq, nb);
      chk_rp("t3", a_rpq, rb);

      // Reset after 4 accepted elements, then a clean re-encode
      pulse_start(1'b0);
      for (int i = 0; i < 4; i++) feed(1'b0, m1[i]);
      dsnap = a_done_cnt;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_a("t5_rst");
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t5_no_done", 64'(a_done_cnt - dsnap), 64'd0);
      e_nz = '{{16'd5, 32'd0}, {16'd1, 32'd0}, {16'd2, 32'd1}, {16'd3, 32'd2}};
      e_rp = '{32'd0, 32'd1, 32'd1, 32'd4};
      nb = a_nzq.size(); rb = a_rpq.size();
      pulse_start(1'b0);
      for (int i = 0; i < 9; i++) feed(1'b0, m1[i]);
      wait_done(1'b0, "t5");
      chk_nz("t5", a_nzq, nb);
      chk_rp("t5", a_rpq, rb);

      // start pulsed during RUN must not disturb the run
      nb = a_nzq.size(); rb = a_rpq.size();
      dsnap = a_done_cnt;
      pulse_start(1'b0);
      for (int i = 0; i < 5; i++) feed(1'b0, m1[i]);
      a_start = 1'b1;
      feed(1'b0, m1[5]);
      a_start = 1'b0;
      chk("t6_busy_mid", 64'(a_busy), 64'd1);
      for (int i = 6; i < 9; i++) feed(1'b0, m1[i]);
      wait_done(1'b0, "t6");
      chk_nz("t6", a_nzq, nb);
      chk_rp("t6", a_rpq, rb);
      chk("t6_done_count", 64'(a_done_cnt - dsnap), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/csr_encoder.md
# csr_encoder

Streaming dense-to-CSR encoder: accepts a dense N_ROWS×N_COLS matrix in row-major order and emits the compressed sparse row streams (`val`/`col` pairs and `rowDelimiters`) consumed by the SpMV kernel. It is the producer end of the CSR interface in the machsuite spmv datapath, used to build the test matrices and to re-encode results on chip. Output channels are valid/ready with one-entry registered slots, so back-pressure from either consumer stalls the input.

## Interface
- `N_ROWS`, default 494: matrix rows.
- `N_COLS`, default 494: matrix columns.
- `MAX_NNZ`, default 1666: capacity of the downstream `val`/`cols` arrays.
- `DATA_W`, default 64: element width, fixed-point.
- `IDX_W`, default 32: column-index and row-pointer width.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin one matrix; ignored unless the block is idle.
- `in_data`  in  DATA_W  dense element.
- `in_valid`  in  1  element valid.
- `in_ready`  out  1  element accepted when `in_valid && in_ready`.
- `nz_val`  out  DATA_W  nonzero value.
- `nz_col`  out  IDX_W  column of `nz_val`.
- `nz_valid`  out  1  nonzero slot occupied.
- `nz_ready`  in  1  consumer takes the nonzero.
- `rp_data`  out  IDX_W  row delimiter, i.e. the cumulative nonzero count.
- `rp_valid`  out  1  delimiter slot occupied.
- `rp_ready`  in  1  consumer takes the delimiter.
- `busy`  out  1  high from `start` accept until `done`.
- `done`  out  1  one-cycle pulse when the matrix is fully drained.
- `overflow`  out  1  sticky; nonzero count exceeded MAX_NNZ.

## Operation
- States: IDLE, HEAD, RUN, DRAIN.
- **IDLE**
  - `start` clears the row, column and nnz counters and `overflow`, then moves to HEAD.
- **HEAD**
  - Loads `rp_data=0` into the delimiter slot when it is free, then moves to RUN.
- **RUN**
  - `in_ready = (!nz_valid || nz_ready) && (!rp_valid || rp_ready)`, combinational.
  - On accept of element (r,c): nonzero means any bit of `in_data` is set.
  - If the element is nonzero and `nnz < MAX_NNZ`: load the nz slot with {`in_data`, c} and increment `nnz`.
  - If the element is nonzero and `nnz == MAX_NNZ`: drop the element and set `overflow`; the counts saturate.
  - c wraps at N_COLS-1. On wrap, load the rp slot with the updated `nnz` (including the current element) and increment r.
  - Accepting (N_ROWS-1, N_COLS-1) moves the block to DRAIN.
- **DRAIN**
  - `in_ready=0`.
  - When both slots are empty, or being emptied this cycle, pulse `done` and return to IDLE.
- Totals: exactly N_ROWS+1 delimiters (first 0, last = final nnz) and nnz nonzero beats per matrix.
- Delimiter ordering:
  - Delimiter k (k≥1) is presented no earlier than the last nonzero of row k-1.
  - The two streams are independent channels; they are not interleaved on one bus.
- A slot that is full holds its data and valid stable until its ready is seen.
- Counter widths:
  - r: $clog2(N_ROWS+1).
  - c: $clog2(N_COLS).
  - nnz: IDX_W.

## Timing
- Reset values: `in_ready=0`, `nz_val=0`, `nz_col=0`, `nz_valid=0`, `rp_data=0`, `rp_valid=0`, `busy=0`, `done=0`, `overflow=0`; state IDLE.
- Reset mid-matrix discards all slot contents the same cycle and returns the block to IDLE. No `done` is generated.
- `start` is sampled in cycle t. `rp_valid` for delimiter 0 rises at t+2 (HEAD at t+1). `in_ready` can first be high at t+2.
- Accept at cycle t: `nz_valid` and/or `rp_valid` rise at t+1. Latency is 1 cycle.
- Full throughput is one element per cycle with both readys held high.
- A simultaneous slot consume and reload in the same cycle keeps valid high with the new data and leaves no bubble.
- `start` while busy is ignored.
- `done` is asserted in the cycle after the last slot handshake and deasserted the next cycle. `busy` falls together with `done`.

## Structure
- Shared package `csr_pkg` holds:
  - constants `CSR_N=494`, `CSR_NNZ=1666`, `CSR_DATA_W=64`, `CSR_IDX_W=32`;
  - the state enum `csr_enc_state_t`.
- The same package is imported by the SpMV kernel so both ends agree on sizes.
- Sub-module `csr_out_slot`: a parameterised one-entry valid/ready register (width generic) with a load strobe and a `free` output. It is instantiated twice, for nz {val, col} and for rp.
- Top `csr_encoder` holds the FSM, the counters and the overflow flag.

## Test plan
- 3×3 matrix [[5,0,0],[0,0,0],[1,2,3]], readys high.
  - nz beats (5,0), (1,0), (2,1), (3,2).
  - rp 0, 1, 1, 4.
  - `done` one cycle after the last beat.
- 2×2 all-zero matrix.
  - No nz beats.
  - rp 0, 0, 0.
  - `overflow=0`.
- 3×3 identity with `nz_ready` low for 5 cycles mid-row 1.
  - `in_ready` stays low throughout the stall.
  - `nz_val`/`nz_col` stay stable.
  - Final streams: nz (1,0), (1,1), (1,2); rp 0, 1, 2, 3.
- MAX_NNZ=2 on a 2×2 all-ones matrix.
  - Only (1,0), (1,1) are emitted.
  - rp 0, 2, 2.
  - `overflow=1` after the 3rd element; it stays sticky until the next `start`.
- Assert `rst` after 4 accepted elements of a 3×3 run.
  - The next cycle shows all outputs at reset values.
  - A fresh `start` re-encodes the matrix correctly from rp 0.
- `start` pulsed during RUN is ignored.
  - The counts and outputs are identical to the undisturbed run.
